// File: rtl/sb_mem_model_pkg.sv
// Shared types for the system-bus slave memory model: access sizes, error
// classes and FSM states.
package sb_mem_model_pkg;

    typedef enum logic [2:0] {
        SB_SIZE_8   = 3'd0,
        SB_SIZE_16  = 3'd1,
        SB_SIZE_32  = 3'd2,
        SB_SIZE_64  = 3'd3,
        SB_SIZE_128 = 3'd4
    } sb_size_e;

    typedef enum logic [1:0] {
        SB_ERR_NONE  = 2'd0,
        SB_ERR_SIZE  = 2'd1,
        SB_ERR_ALIGN = 2'd2,
        SB_ERR_RANGE = 2'd3
    } sb_err_e;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_WAIT = 2'd1,
        SB_RESP = 2'd2
    } sb_state_e;

    // Widest access the bus can carry in one beat.
    function automatic sb_size_e sb_max_size(input int data_width);
        return (data_width == 32) ? SB_SIZE_32 : SB_SIZE_64;
    endfunction

endpackage

// File: rtl/sb_mem_model_if.sv
// System-bus request/response bundle between the debug module (master) and
// the memory model (slave).
interface sb_mem_model_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] sb_address;
    logic [DATA_WIDTH-1:0] sb_wdata;
    logic [2:0]            sb_size;
    logic                  sb_read_req;
    logic                  sb_write_req;
    logic [DATA_WIDTH-1:0] sb_rdata;
    logic                  sb_ready;
    logic                  sb_done;
    logic                  sb_error;
    logic [1:0]            sb_err_cause;

    modport master (
        output sb_address, sb_wdata, sb_size, sb_read_req, sb_write_req,
        input  sb_rdata, sb_ready, sb_done, sb_error, sb_err_cause
    );

    modport slave (
        input  sb_address, sb_wdata, sb_size, sb_read_req, sb_write_req,
        output sb_rdata, sb_ready, sb_done, sb_error, sb_err_cause
    );
endinterface

// File: rtl/sb_mem_model_lane_align.sv
// Byte-lane steering: right-justifies read data from a word and merges
// right-justified write data into the addressed lanes of a word.
module sb_lane_align #(
    parameter  int DATA_WIDTH = 64,
    localparam int NBYTES     = DATA_WIDTH / 8,
    localparam int LANE_W     = $clog2(NBYTES)
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [LANE_W-1:0]     lane,
    input  logic [2:0]            size,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] merged
);
    int n_bytes;
    int lane_i;

    always_comb begin
        rdata   = '0;
        merged  = word;
        n_bytes = 1 << size;
        lane_i  = int'(lane);
        for (int i = 0; i < NBYTES; i++) begin
            if (i < n_bytes && (lane_i + i) < NBYTES)
                rdata[i*8 +: 8] = word[(lane_i + i)*8 +: 8];
            if (i >= lane_i && i < lane_i + n_bytes)
                merged[i*8 +: 8] = wdata[(i - lane_i)*8 +: 8];
        end
    end
endmodule

// File: rtl/sb_mem_model.sv
// Parametrised system-bus slave memory with configurable latency, lane
// handling, classified error responses and a saturating error counter.
//   state   | meaning
//   SB_IDLE | sb_ready high, request accepted and executed on this edge
//   SB_WAIT | latency countdown, sb_ready low
//   SB_RESP | last busy cycle, sb_done high
module sb_mem_model
    import sb_mem_model_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    LATENCY    = 1,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sb_mem_model_if.slave        sb,
    output logic [CNT_WIDTH-1:0] err_count
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(NBYTES);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(DEPTH * NBYTES);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    sb_state_e             state_q;
    logic [3:0]            cnt_q;
    logic                  ready_q;
    logic                  done_q;
    logic                  error_q;
    sb_err_e               cause_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  req;
    logic                  misaligned;
    logic                  out_of_range;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic [IDX_W-1:0]      word_idx;
    logic [LANE_W-1:0]     lane;
    sb_err_e               chk_cause;
    logic [DATA_WIDTH-1:0] cur_word;
    logic [DATA_WIDTH-1:0] rd_aligned;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic                  accept;

    assign req          = sb.sb_read_req | sb.sb_write_req;
    assign accept       = (state_q == SB_IDLE) && req;
    assign align_mask   = (ADDR_WIDTH'(1) << sb.sb_size) - ADDR_WIDTH'(1);
    assign misaligned   = (sb.sb_address & align_mask) != '0;
    assign offset       = sb.sb_address - BASE_ADDR;
    assign out_of_range = (sb.sb_address < BASE_ADDR) || (offset >= MEM_BYTES);
    assign lane         = offset[LANE_W-1:0];
    // Keep the array index legal even when the request is going to be rejected.
    assign word_idx     = out_of_range ? '0 : offset[LANE_W +: IDX_W];
    assign cur_word     = mem[word_idx];

    always_comb begin
        chk_cause = SB_ERR_NONE;
        if ((sb.sb_read_req && sb.sb_write_req) || (sb.sb_size > sb_max_size(DATA_WIDTH)))
            chk_cause = SB_ERR_SIZE;
        else if (misaligned)
            chk_cause = SB_ERR_ALIGN;
        else if (out_of_range)
            chk_cause = SB_ERR_RANGE;
    end

    sb_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane_align (
        .word   (cur_word),
        .lane   (lane),
        .size   (sb.sb_size),
        .wdata  (sb.sb_wdata),
        .rdata  (rd_aligned),
        .merged (wr_merged)
    );

    // Contents are deliberately not reset so they survive a bus reset.
    always_ff @(posedge clk) begin
        if (!rst && accept && chk_cause == SB_ERR_NONE && sb.sb_write_req)
            mem[word_idx] <= wr_merged;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SB_IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cause_q   <= SB_ERR_NONE;
            rdata_q   <= '0;
            err_count <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                SB_IDLE: begin
                    if (req) begin
                        ready_q <= 1'b0;
                        error_q <= (chk_cause != SB_ERR_NONE);
                        cause_q <= chk_cause;
                        rdata_q <= (chk_cause == SB_ERR_NONE && sb.sb_read_req) ? rd_aligned : '0;
                        if (chk_cause != SB_ERR_NONE && err_count != '1)
                            err_count <= err_count + 1'b1;
                        if (LATENCY == 1) begin
                            state_q <= SB_RESP;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SB_WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                SB_WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == 4'd1) begin
                        state_q <= SB_RESP;
                        done_q  <= 1'b1;
                    end
                end
                SB_RESP: begin
                    state_q <= SB_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= SB_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign sb.sb_ready     = ready_q;
    assign sb.sb_done      = done_q;
    assign sb.sb_error     = error_q;
    assign sb.sb_err_cause = cause_q;
    assign sb.sb_rdata     = rdata_q;
endmodule
